// File: rtl/multi_rate_divider.sv
// NUM_CH independent 50%-duty clock dividers with tick strobes and glitch-free runtime
// half-period reprogramming. Define DIV_PHASE_SYNC_EN to add the sync phase-restart input.
module multi_rate_divider #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned DEFAULT_HALF = 3333333
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
`ifdef DIV_PHASE_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

  logic sync_req;

`ifdef DIV_PHASE_SYNC_EN
  assign sync_req = sync;
`else
  assign sync_req = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(i);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_next;
    logic [CNT_W-1:0] nxt;
    logic [CNT_W-1:0] nxt_next;
    logic [CNT_W-1:0] term;
    logic             pend;
    logic             pend_next;
    logic             div;
    logic             div_next;
    logic             tck;
    logic             tck_next;
    logic             at_term;
    logic             wr_hit;
    logic             boundary;

    // A pending half-period is only ever swapped in at an interval boundary (terminal
    // count, disable or sync), so the counter can never sit above the new terminal value.
    always_comb begin
      term      = (half == '0) ? '0 : half - CNT_W'(1);
      at_term   = (cnt == term);
      wr_hit    = cfg_wr && (cfg_ch == CH_IDX);
      cnt_next  = cnt;
      half_next = half;
      nxt_next  = nxt;
      pend_next = pend;
      div_next  = div;
      tck_next  = 1'b0;
      boundary  = 1'b0;

      if (!ch_en[i] || sync_req) begin
        cnt_next = '0;
        div_next = 1'b0;
        boundary = 1'b1;
      end else if (at_term) begin
        cnt_next = '0;
        div_next = ~div;
        tck_next = 1'b1;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end

      if (boundary && pend) begin
        half_next = nxt;
        pend_next = 1'b0;
      end

      // A write landing on a boundary cycle queues behind the value applied there.
      if (wr_hit) begin
        nxt_next  = cfg_half;
        pend_next = 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt  <= '0;
        half <= RESET_HALF;
        nxt  <= RESET_HALF;
        pend <= 1'b0;
        div  <= 1'b0;
        tck  <= 1'b0;
      end else begin
        cnt  <= cnt_next;
        half <= half_next;
        nxt  <= nxt_next;
        pend <= pend_next;
        div  <= div_next;
        tck  <= tck_next;
      end
    end

    assign div_clk[i]     = div;
    assign tick[i]        = tck;
    assign cfg_pending[i] = pend;
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Self-checking bench for multi_rate_divider: hand-derived vector table, a countdown
// reference model feeding a scoreboard queue, and directed multi-cycle corner sequences.
module tb_multi_rate_divider;

  localparam int NUM_CH       = 2;
  localparam int CNT_W        = 4;
  localparam int DEFAULT_HALF = 3;

`ifdef DIV_PHASE_SYNC_EN
  localparam bit HAS_SYNC = 1'b1;
`else
  localparam bit HAS_SYNC = 1'b0;
`endif

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic [1:0] ch_en    = 2'b00;
  logic       cfg_wr   = 1'b0;
  logic [3:0] cfg_ch   = 4'd0;
  logic [3:0] cfg_half = 4'd0;
  logic       sync     = 1'b0;
  logic [1:0] div_clk;
  logic [1:0] tick;
  logic [1:0] cfg_pending;

  multi_rate_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_HALF(DEFAULT_HALF)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ch_en(ch_en),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
`ifdef DIV_PHASE_SYNC_EN
    .sync(sync),
`endif
    .div_clk(div_clk),
    .tick(tick),
    .cfg_pending(cfg_pending)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] div;
    logic [1:0] tck;
    logic [1:0] pend;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic       wr;
    logic [3:0] ch;
    logic [3:0] half;
    logic [1:0] ediv;
    logic [1:0] etick;
    logic [1:0] epend;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: m_rem counts edges left until the next toggle.
  int         m_rem[2];
  logic [3:0] m_half[2];
  logic [3:0] m_nxt[2];
  logic [1:0] m_pend = 2'b00;
  logic [1:0] m_div  = 2'b00;
  logic [1:0] m_tick = 2'b00;

  function automatic int eff(input logic [3:0] h);
    return (h == 4'd0) ? 1 : int'(h);
  endfunction

  task automatic modelStep();
    logic sync_now;
    logic boundary;
    sync_now = HAS_SYNC && sync;
    for (int c = 0; c < 2; c++) begin
      if (RST) begin
        m_half[c] = 4'(DEFAULT_HALF);
        m_nxt[c]  = 4'(DEFAULT_HALF);
        m_pend[c] = 1'b0;
        m_div[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_rem[c]  = eff(4'(DEFAULT_HALF));
      end else begin
        boundary  = 1'b1;
        m_tick[c] = 1'b0;
        if (!ch_en[c] || sync_now) begin
          m_div[c] = 1'b0;
        end else if (m_rem[c] == 1) begin
          m_div[c]  = ~m_div[c];
          m_tick[c] = 1'b1;
        end else begin
          m_rem[c] = m_rem[c] - 1;
          boundary = 1'b0;
        end
        if (boundary) begin
          if (m_pend[c]) begin
            m_half[c] = m_nxt[c];
            m_pend[c] = 1'b0;
          end
          m_rem[c] = eff(m_half[c]);
        end
        if (cfg_wr && cfg_ch == 4'(c)) begin
          m_nxt[c]  = cfg_half;
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty cycle %0d", cyc);
    end else begin
      e = exp_q.pop_front();
      if ({div_clk, tick, cfg_pending} !== e) begin
        errors++;
        $display("[TB] FAIL scoreboard cycle %0d: got div=%b tick=%b pend=%b, expected div=%b tick=%b pend=%b",
                 cyc, div_clk, tick, cfg_pending, e.div, e.tck, e.pend);
      end
    end
  endtask

  task automatic applyStimulus();
    @(posedge CLK);
    modelStep();
    exp_q.push_back({m_div, m_tick, m_pend});
    @(negedge CLK);
    cyc++;
    checkOutput();
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic writeCfg(input logic [3:0] ch, input logic [3:0] h);
    cfg_wr   = 1'b1;
    cfg_ch   = ch;
    cfg_half = h;
    applyStimulus();
    cfg_wr   = 1'b0;
  endtask

  task automatic waitPendClear(input int ch);
    for (int k = 0; k < 40 && m_pend[ch]; k++) applyStimulus();
    checkValue("pend_cleared", 32'(cfg_pending[ch]), 32'd0);
  endtask

  // Edges until the next tick on channel ch; -1 if none within the budget.
  task automatic measureTick(input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus();
      if (tick[ch] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int t0;
    int t1;

    vecs[0]  = '{1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b11, 2'b11, 2'b00};
    vecs[5]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b11, 2'b00, 2'b00};
    vecs[6]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b11, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 2'b11, 2'b00};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 4'd0, 4'd5, 2'b00, 2'b00, 2'b01};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b11, 2'b11, 2'b00};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b11, 2'b00, 2'b00};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b11, 2'b00, 2'b00};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b01, 2'b10, 2'b00};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00};

    // Reset, first enable and a mid-interval reprogram of ch0 to 5.
    for (int i = 0; i < 16; i++) begin
      RST      = vecs[i].rst;
      ch_en    = vecs[i].en;
      cfg_wr   = vecs[i].wr;
      cfg_ch   = vecs[i].ch;
      cfg_half = vecs[i].half;
      applyStimulus();
      checks++;
      if ({div_clk, tick, cfg_pending} !== {vecs[i].ediv, vecs[i].etick, vecs[i].epend}) begin
        errors++;
        $display("[TB] FAIL table row %0d: got div=%b tick=%b pend=%b, expected div=%b tick=%b pend=%b",
                 i, div_clk, tick, cfg_pending, vecs[i].ediv, vecs[i].etick, vecs[i].epend);
      end
    end
    cfg_wr = 1'b0;

    // half=1 and half=0 both toggle every cycle with tick held high.
    writeCfg(4'd0, 4'd1);
    checkValue("pend_after_wr_half1", 32'(cfg_pending[0]), 32'd1);
    waitPendClear(0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkValue("tick_half1", 32'(tick[0]), 32'd1);
    end
    writeCfg(4'd0, 4'd0);
    waitPendClear(0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkValue("tick_half0", 32'(tick[0]), 32'd1);
    end
    writeCfg(4'd15, 4'd9);
    checkValue("ignored_ch15", 32'(cfg_pending), 32'd0);

    // Collision: a write on the terminal-count cycle queues behind the pending value.
    writeCfg(4'd0, 4'd3);
    waitPendClear(0);
    for (int k = 0; k < 10 && m_rem[0] == 1; k++) applyStimulus();
    writeCfg(4'd0, 4'd4);
    for (int k = 0; k < 10 && m_rem[0] != 1; k++) applyStimulus();
    writeCfg(4'd0, 4'd2);
    checkValue("collision_tick", 32'(tick[0]), 32'd1);
    checkValue("collision_pend", 32'(cfg_pending[0]), 32'd1);
    measureTick(0, n);
    checkValue("collision_interval_old", 32'(n), 32'd4);
    checkValue("collision_pend_clear", 32'(cfg_pending[0]), 32'd0);
    measureTick(0, n);
    checkValue("collision_interval_new", 32'(n), 32'd2);
    measureTick(0, n);
    checkValue("collision_interval_new2", 32'(n), 32'd2);

    // Disabling ch1 during its high phase forces it low on the next edge.
    for (int k = 0; k < 20 && m_div[1] == 1'b0; k++) applyStimulus();
    checkValue("pre_disable_div1", 32'(div_clk[1]), 32'd1);
    ch_en = 2'b01;
    applyStimulus();
    checkValue("disable_div1", 32'(div_clk[1]), 32'd0);
    checkValue("disable_tick1", 32'(tick[1]), 32'd0);
    ch_en = 2'b11;
    measureTick(1, n);
    checkValue("reenable_first_tick", 32'(n), 32'd3);

    // Reset mid-run discards a pending write and restores the default half.
    writeCfg(4'd1, 4'd7);
    checkValue("pend_before_rst", 32'(cfg_pending[1]), 32'd1);
    RST = 1'b1;
    applyStimulus();
    RST = 1'b0;
    checkValue("rst_pend", 32'(cfg_pending), 32'd0);
    checkValue("rst_div", 32'(div_clk), 32'd0);
    measureTick(1, n);
    checkValue("rst_first_tick", 32'(n), 32'd3);
    measureTick(1, n);
    checkValue("rst_default_interval", 32'(n), 32'd3);

`ifdef DIV_PHASE_SYNC_EN
    writeCfg(4'd1, 4'd5);
    waitPendClear(1);
    applyStimulus();
    applyStimulus();
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    checkValue("sync_div", 32'(div_clk), 32'd0);
    checkValue("sync_tick", 32'(tick), 32'd0);
    t0 = -1;
    t1 = -1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus();
      if (tick[0] === 1'b1 && t0 < 0) t0 = k;
      if (tick[1] === 1'b1 && t1 < 0) t1 = k;
    end
    checkValue("sync_ch0_first_tick", 32'(t0), 32'd3);
    checkValue("sync_ch1_first_tick", 32'(t1), 32'd5);
`else
    t0 = 0;
    t1 = 0;
`endif

    applyStimulus();
    checkValue("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
